// File: rtl/mem_responder_if.sv
// Request/response bus between the datapath and the data memory responder.
// Signal names match the original flat port list so callers map one-to-one.
interface mem_responder_if;
  logic [15:0] Address;
  logic [15:0] DataIn;
  logic        Req;
  logic        WE;
  logic        Wide;
  logic [15:0] DataOut;
  logic        Ack;
  logic        Busy;

  modport master (
    output Address, DataIn, Req, WE, Wide,
    input  DataOut, Ack, Busy
  );

  modport slave (
    input  Address, DataIn, Req, WE, Wide,
    output DataOut, Ack, Busy
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-organised data memory with programmable wait states.
// Performs 8-bit or 16-bit little-endian accesses and pulses Ack on completion.
module mem_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic            Clock,
  input logic            Reset,
  mem_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BYTE0,
    S_BYTE1,
    S_DONE
  } state_t;

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [7:0] mem [0:DEPTH-1];

  state_t                 state_q, state_d;
  logic [3:0]             wait_q, wait_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   wide_q, wide_d;
  logic [7:0]             lo_q, lo_d;
  logic [15:0]            dout_q, dout_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;

  logic [ADDR_BITS-1:0]   addr_p1;
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [7:0]             mem_wdata;
  logic                   unused_addr_hi;

  // Upper address bits are ignored; fold them into a sink.
  assign unused_addr_hi = ^bus.Address;

  // High byte of a wide access wraps within the implemented address space.
  assign addr_p1 = addr_q + ADDR_BITS'(1);

  // Next-state, request latching, read capture and output pulse generation.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    wide_d  = wide_q;
    lo_d    = lo_q;
    dout_d  = dout_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Req) begin
          addr_d  = bus.Address[ADDR_BITS-1:0];
          wdata_d = bus.DataIn;
          we_d    = bus.WE;
          wide_d  = bus.Wide;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            wait_d  = WAIT_LOAD;
          end else begin
            state_d = S_BYTE0;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = S_BYTE0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_BYTE0: begin
        lo_d = mem[addr_q];
        if (wide_q) begin
          state_d = S_BYTE1;
        end else begin
          state_d = S_DONE;
          if (!we_q) begin
            dout_d = {8'h00, mem[addr_q]};
          end
        end
      end
      S_BYTE1: begin
        state_d = S_DONE;
        if (!we_q) begin
          dout_d = {mem[addr_p1], lo_q};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ack_d  = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // Control and datapath registers; synchronous reset aborts any access.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wide_q  <= 1'b0;
      lo_q    <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wide_q  <= wide_d;
      lo_q    <= lo_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Select which byte (if any) is written this cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q[7:0];
    if (we_q && (state_q == S_BYTE0)) begin
      mem_we = 1'b1;
    end else if (we_q && (state_q == S_BYTE1)) begin
      mem_we    = 1'b1;
      mem_waddr = addr_p1;
      mem_wdata = wdata_q[15:8];
    end
  end

  // Byte array is not cleared by reset; a reset on the same edge suppresses the write.
  always_ff @(posedge Clock) begin
    if (!Reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.Ack     = ack_q;
  assign bus.Busy    = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (W=1 and W=0 instances).
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_responder_if b1 ();
  mem_responder_if b0 ();

  mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(1)) u_w1 (
    .Clock (clk),
    .Reset (rst),
    .bus   (b1)
  );

  mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_w0 (
    .Clock (clk),
    .Reset (rst),
    .bus   (b0)
  );

  function automatic logic get_ack(input bit sel);
    return sel ? b0.Ack : b1.Ack;
  endfunction

  function automatic logic [15:0] get_dout(input bit sel);
    return sel ? b0.DataOut : b1.DataOut;
  endfunction

  // Stimulus only: issue one request (sel 0 = W1 DUT, 1 = W0 DUT), report
  // DataOut at Ack and the edge number (accept = edge 0) of the Ack.
  task automatic access(input bit sel, input logic [15:0] a, input logic [15:0] d,
                        input bit we, input bit wide,
                        output logic [15:0] dout, output int ack_edge);
    @(negedge clk);
    if (sel) begin
      b0.Address = a; b0.DataIn = d; b0.WE = we; b0.Wide = wide; b0.Req = 1'b1;
    end else begin
      b1.Address = a; b1.DataIn = d; b1.WE = we; b1.Wide = wide; b1.Req = 1'b1;
    end
    @(posedge clk); #1;
    b0.Req = 1'b0; b1.Req = 1'b0;
    ack_edge = -1;
    dout = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (get_ack(sel)) begin
        ack_edge = n;
        dout = get_dout(sel);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b1.Req = 1'b1; b1.WE = 1'b1; b1.Wide = 1'b1; b1.Address = 16'h0050; b1.DataIn = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (b1.DataOut !== 16'h0000) begin n_bad++; $display("FAIL reset_dout got=%h exp=0000", b1.DataOut); end
      n_cmp++; if (b1.Ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", b1.Ack); end
      n_cmp++; if (b1.Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", b1.Busy); end
    end
    rst = 1'b0;
    b1.Req = 1'b0; b1.WE = 1'b0; b1.Wide = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (b1.Busy !== 1'b0) begin n_bad++; $display("FAIL reset_no_start got=%b exp=0", b1.Busy); end
  endtask

  task automatic test_wide_rw();
    logic [15:0] d; int e;
    access(1'b0, 16'h0010, 16'hBEEF, 1'b1, 1'b1, d, e);
    n_cmp++; if (e != 3) begin n_bad++; $display("FAIL wide_wr_ack_edge got=%0d exp=3", e); end
    n_cmp++; if (b1.DataOut !== 16'h0000) begin n_bad++; $display("FAIL wr_keeps_dout got=%h exp=0000", b1.DataOut); end
    access(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, d, e);
    n_cmp++; if (e != 3) begin n_bad++; $display("FAIL wide_rd_ack_edge got=%0d exp=3", e); end
    n_cmp++; if (d !== 16'hBEEF) begin n_bad++; $display("FAIL wide_rd_data got=%h exp=BEEF", d); end
    access(1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, d, e);
    n_cmp++; if (e != 2) begin n_bad++; $display("FAIL narrow_rd_ack_edge got=%0d exp=2", e); end
    n_cmp++; if (d !== 16'h00BE) begin n_bad++; $display("FAIL narrow_rd_data got=%h exp=00BE", d); end
    n_cmp++; if (b1.Busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_done got=%b exp=0", b1.Busy); end
  endtask

  task automatic test_wrap();
    logic [15:0] d; int e;
    access(1'b0, 16'h03FF, 16'h1234, 1'b1, 1'b1, d, e);
    access(1'b0, 16'h03FF, 16'h0000, 1'b0, 1'b0, d, e);
    n_cmp++; if (d !== 16'h0034) begin n_bad++; $display("FAIL wrap_lo got=%h exp=0034", d); end
    access(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, d, e);
    n_cmp++; if (d !== 16'h0012) begin n_bad++; $display("FAIL wrap_hi got=%h exp=0012", d); end
    access(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, d, e);
    n_cmp++; if (d !== 16'h1234) begin n_bad++; $display("FAIL wrap_alias got=%h exp=1234", d); end
  endtask

  task automatic test_ignore_busy();
    logic [15:0] d; int e; int acks; int ack_at;
    access(1'b0, 16'h0020, 16'h005A, 1'b1, 1'b0, d, e);
    access(1'b0, 16'h0030, 16'h0077, 1'b1, 1'b0, d, e);
    @(negedge clk);
    b1.Address = 16'h0020; b1.WE = 1'b0; b1.Wide = 1'b0; b1.Req = 1'b1;
    @(posedge clk); #1;
    b1.Req = 1'b0; b1.Address = 16'h0030; b1.WE = 1'b1; b1.Wide = 1'b1; b1.DataIn = 16'hFFFF;
    acks = 0; ack_at = -1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      b1.WE = 1'b0;
      if (b1.Ack) begin
        acks++;
        ack_at = n;
        n_cmp++; if (b1.DataOut !== 16'h005A) begin n_bad++; $display("FAIL busy_ign_data got=%h exp=005A", b1.DataOut); end
      end
    end
    n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL busy_ign_ack_count got=%0d exp=1", acks); end
    n_cmp++; if (ack_at != 2) begin n_bad++; $display("FAIL busy_ign_ack_edge got=%0d exp=2", ack_at); end
    b1.Wide = 1'b0;
    access(1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, d, e);
    n_cmp++; if (d !== 16'h0077) begin n_bad++; $display("FAIL busy_ign_mem30 got=%h exp=0077", d); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; int e; int acks;
    access(1'b0, 16'h0040, 16'h0000, 1'b1, 1'b1, d, e);
    @(negedge clk);
    b1.Address = 16'h0040; b1.DataIn = 16'hAA55; b1.WE = 1'b1; b1.Wide = 1'b1; b1.Req = 1'b1;
    @(posedge clk); #1;             // edge 0 -> WAIT
    b1.Req = 1'b0;
    @(posedge clk); #1;             // edge 1 -> BYTE0
    @(posedge clk); #1;             // edge 2 -> BYTE1 (low byte written)
    n_cmp++; if (b1.Busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got=%b exp=1", b1.Busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (b1.Busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy_after got=%b exp=0", b1.Busy); end
    n_cmp++; if (b1.DataOut !== 16'h0000) begin n_bad++; $display("FAIL mid_dout got=%h exp=0000", b1.DataOut); end
    acks = 0;
    for (int n = 0; n < 4; n++) begin
      if (b1.Ack) acks++;
      @(posedge clk); #1;
    end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL mid_no_ack got=%0d exp=0", acks); end
    access(1'b0, 16'h0040, 16'h0000, 1'b0, 1'b1, d, e);
    n_cmp++; if (d !== 16'h0055) begin n_bad++; $display("FAIL mid_partial got=%h exp=0055", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; int e;
    logic [5:0] ackv, busyv;
    logic [15:0] d1, d4;
    access(1'b1, 16'h0008, 16'h3CC3, 1'b1, 1'b1, d, e);
    n_cmp++; if (e != 2) begin n_bad++; $display("FAIL w0_wide_ack_edge got=%0d exp=2", e); end
    @(negedge clk);
    b0.Address = 16'h0008; b0.WE = 1'b0; b0.Wide = 1'b0; b0.Req = 1'b1;
    @(posedge clk); #1;             // edge 0
    ackv[0] = b0.Ack; busyv[0] = b0.Busy;
    b0.Address = 16'h0009;
    d1 = 'x; d4 = 'x;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      ackv[n] = b0.Ack; busyv[n] = b0.Busy;
      if (n == 1) d1 = b0.DataOut;
      if (n == 4) d4 = b0.DataOut;
      if (n == 3) b0.Req = 1'b0;
    end
    n_cmp++; if (ackv !== 6'b010010) begin n_bad++; $display("FAIL b2b_ack_pattern got=%b exp=010010", ackv); end
    n_cmp++; if (busyv !== 6'b011011) begin n_bad++; $display("FAIL b2b_busy_pattern got=%b exp=011011", busyv); end
    n_cmp++; if (d1 !== 16'h00C3) begin n_bad++; $display("FAIL b2b_first got=%h exp=00C3", d1); end
    n_cmp++; if (d4 !== 16'h003C) begin n_bad++; $display("FAIL b2b_second got=%h exp=003C", d4); end
  endtask

  initial begin
    b0.Req = 1'b0; b0.WE = 1'b0; b0.Wide = 1'b0; b0.Address = '0; b0.DataIn = '0;
    b1.Req = 1'b0; b1.WE = 1'b0; b1.Wide = 1'b0; b1.Address = '0; b1.DataIn = '0;
    rst = 1'b1;
    test_reset();
    test_wide_rw();
    test_wrap();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
